// File: rtl/carry_chain_pipelined.sv
// Pipelined mux-carry chain: one register stage per SEG-bit segment, with P/G
// skew and sum de-skew registers so every sum bit and Co of a set emerge together.
module carry_chain_pipelined #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] G,
  input  logic             Ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  localparam int STAGES = WIDTH / SEG;

  if (SEG < 1 || WIDTH < 1 || (WIDTH % SEG) != 0) begin : g_param_check
    $error("carry_chain_pipelined: WIDTH must be a positive multiple of SEG");
  end

  logic              adv;
  logic [STAGES-1:0] valid_d, valid_q;
  logic [STAGES-1:0] seg_cout;

  // One global enable: the whole pipe moves or the whole pipe holds.
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign Co        = seg_cout[STAGES-1];

  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = adv ? in_valid : valid_q[0];
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = adv ? valid_q[k-1] : valid_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_seg
    // Sum bits of segment j still need STAGES-1-j de-skew advances after stage j.
    localparam int SD = STAGES - j;

    logic [SEG-1:0] p_use, g_use, sum_d;
    logic [SEG:0]   c_chain;
    logic           cin, carry_d, carry_q;
    logic [SEG-1:0] s_dly_d [SD];
    logic [SEG-1:0] s_dly_q [SD];

    if (j == 0) begin : g_head
      assign p_use = P[SEG-1:0];
      assign g_use = G[SEG-1:0];
      assign cin   = Ci;
    end else begin : g_skew
      logic [SEG-1:0] p_sk_d [j];
      logic [SEG-1:0] p_sk_q [j];
      logic [SEG-1:0] g_sk_d [j];
      logic [SEG-1:0] g_sk_q [j];

      always_comb begin
        p_sk_d = p_sk_q;
        g_sk_d = g_sk_q;
        if (adv) begin
          p_sk_d[0] = P[j*SEG +: SEG];
          g_sk_d[0] = G[j*SEG +: SEG];
          for (int i = 1; i < j; i++) begin
            p_sk_d[i] = p_sk_q[i-1];
            g_sk_d[i] = g_sk_q[i-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < j; i++) begin
            p_sk_q[i] <= '0;
            g_sk_q[i] <= '0;
          end
        end else begin
          p_sk_q <= p_sk_d;
          g_sk_q <= g_sk_d;
        end
      end

      assign p_use = p_sk_q[j-1];
      assign g_use = g_sk_q[j-1];
      assign cin   = seg_cout[j-1];
    end

    // Plain mux-carry ripple inside the segment; no lookahead.
    always_comb begin
      sum_d      = '0;
      c_chain    = '0;
      c_chain[0] = cin;
      for (int b = 0; b < SEG; b++) begin
        sum_d[b]     = p_use[b] ^ c_chain[b];
        c_chain[b+1] = p_use[b] ? c_chain[b] : g_use[b];
      end
      carry_d = adv ? c_chain[SEG] : carry_q;
    end

    always_comb begin
      s_dly_d = s_dly_q;
      if (adv) begin
        s_dly_d[0] = sum_d;
        for (int i = 1; i < SD; i++) begin
          s_dly_d[i] = s_dly_q[i-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        carry_q <= 1'b0;
        for (int i = 0; i < SD; i++) s_dly_q[i] <= '0;
      end else begin
        carry_q <= carry_d;
        s_dly_q <= s_dly_d;
      end
    end

    assign seg_cout[j]       = carry_q;
    assign S[j*SEG +: SEG]   = s_dly_q[SD-1];
  end

endmodule

// File: tb/tb_carry_chain_pipelined.sv
// Directed self-checking bench for carry_chain_pipelined, plus a small
// parameter sweep against a single-cycle ripple reference.
module tb_carry_chain_pipelined;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, ci, co;
  logic [15:0] p, g, s;

  int assert_count = 0;
  int fail_count   = 0;

  // Shared drive for the sweep instances
  logic        sw_valid, sw_ready, sw_ci;
  logic [31:0] sw_p, sw_g;
  logic [3:0]  s4_4;
  logic [7:0]  s8_4, s8_2;
  logic [31:0] s32_8;
  logic co4_4, co8_4, co8_2, co32_8;
  logic ov4_4, ov8_4, ov8_2, ov32_8;
  logic ir4_4, ir8_4, ir8_2, ir32_8;

  carry_chain_pipelined #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .P(p), .G(g), .Ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .S(s), .Co(co));

  carry_chain_pipelined #(.WIDTH(4), .SEG(4)) u_w4s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir4_4),
    .P(sw_p[3:0]), .G(sw_g[3:0]), .Ci(sw_ci), .out_valid(ov4_4),
    .out_ready(sw_ready), .S(s4_4), .Co(co4_4));

  carry_chain_pipelined #(.WIDTH(8), .SEG(4)) u_w8s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir8_4),
    .P(sw_p[7:0]), .G(sw_g[7:0]), .Ci(sw_ci), .out_valid(ov8_4),
    .out_ready(sw_ready), .S(s8_4), .Co(co8_4));

  carry_chain_pipelined #(.WIDTH(8), .SEG(2)) u_w8s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir8_2),
    .P(sw_p[7:0]), .G(sw_g[7:0]), .Ci(sw_ci), .out_valid(ov8_2),
    .out_ready(sw_ready), .S(s8_2), .Co(co8_2));

  carry_chain_pipelined #(.WIDTH(32), .SEG(8)) u_w32s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir32_8),
    .P(sw_p), .G(sw_g), .Ci(sw_ci), .out_valid(ov32_8),
    .out_ready(sw_ready), .S(s32_8), .Co(co32_8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic c, input logic v);
    p        = a ^ b;
    g        = a & b;
    ci       = c;
    in_valid = v;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference: bit-serial mux-carry over w bits, returns {Co, S}
  function automatic logic [63:0] rippleModel(input logic [31:0] pp, input logic [31:0] gg,
                                              input logic cc, input int w);
    logic [63:0] r;
    logic        c;
    r = '0;
    c = cc;
    for (int i = 0; i < w; i++) begin
      r[i] = pp[i] ^ c;
      c    = pp[i] ? c : gg[i];
    end
    r[w] = c;
    return r;
  endfunction

  task automatic sweepVector(input logic [31:0] vp, input logic [31:0] vg,
                             input logic vc, input logic check_lat);
    sw_p = vp; sw_g = vg; sw_ci = vc; sw_valid = 1'b1; sw_ready = 1'b0;
    step();
    sw_valid = 1'b0;
    if (check_lat) checkOutput("w8s4_lat_edge1", 64'(ov8_4), 64'd0);
    step();
    if (check_lat) begin
      checkOutput("w8s4_lat_edge2", 64'(ov8_4), 64'd1);
      checkOutput("w8s4_ff_plus_01", 64'({co8_4, s8_4}), 64'h100);
    end
    repeat (4) step();
    checkOutput("sweep_valid", 64'({ov4_4, ov8_4, ov8_2, ov32_8}), 64'hF);
    checkOutput("sweep_w4s4",  64'({co4_4, s4_4}),   rippleModel(vp, vg, vc, 4));
    checkOutput("sweep_w8s4",  64'({co8_4, s8_4}),   rippleModel(vp, vg, vc, 8));
    checkOutput("sweep_w8s2",  64'({co8_2, s8_2}),   rippleModel(vp, vg, vc, 8));
    checkOutput("sweep_w32s8", 64'({co32_8, s32_8}), rippleModel(vp, vg, vc, 32));
    sw_ready = 1'b1;
    step();
    sw_ready = 1'b0;
    checkOutput("sweep_drain", 64'({ov4_4, ov8_4, ov8_2, ov32_8}), 64'h0);
  endtask

  initial begin
    logic stale;
    rst_n = 1'b0; out_ready = 1'b1;
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
    sw_valid = 1'b0; sw_ready = 1'b0; sw_ci = 1'b0; sw_p = '0; sw_g = '0;
    #2;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_sum_co",    64'({co, s}),   64'd0);
    checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
    step();
    rst_n = 1'b1;

    // Back-to-back sets, result stream starts 4 edges after the first accept
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b1);
    step();
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    step();
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    checkOutput("b2b_latency_edge3", 64'(out_valid), 64'd0);
    step();
    checkOutput("b2b_r1_valid", 64'(out_valid), 64'd1);
    checkOutput("b2b_r1",       64'({co, s}),   64'h02345);
    step();
    checkOutput("b2b_r2",       64'({out_valid, co, s}), 64'h30000);
    step();
    checkOutput("b2b_r3",       64'({out_valid, co, s}), 64'h30000);
    step();
    checkOutput("b2b_empty",    64'(out_valid), 64'd0);

    // Backpressure: fill with four sets, hold a fifth at the input
    out_ready = 1'b0;
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b1); step();
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b1); step();
    applyStimulus(16'hF000, 16'h1000, 1'b0, 1'b1); step();
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b1); step();
    applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_hold",     64'({out_valid, co, s}), 64'h20002);
      step();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    checkOutput("bp_drain_b", 64'({out_valid, co, s}), 64'h20100);
    step();
    checkOutput("bp_drain_c", 64'({out_valid, co, s}), 64'h30000);
    step();
    checkOutput("bp_drain_d", 64'({out_valid, co, s}), 64'h28000);
    step();
    checkOutput("bp_drain_e", 64'({out_valid, co, s}), 64'h25556);
    step();
    checkOutput("bp_drain_end", 64'(out_valid), 64'd0);

    // Bubble pattern 1,0,1 must come out as 1,0,1
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b1); step();
    in_valid = 1'b0; step();
    applyStimulus(16'hAAAA, 16'h5556, 1'b0, 1'b1); step();
    in_valid = 1'b0; step();
    checkOutput("bubble_x",   64'({out_valid, co, s}), 64'h21000);
    step();
    checkOutput("bubble_gap", 64'(out_valid), 64'd0);
    step();
    checkOutput("bubble_y",   64'({out_valid, co, s}), 64'h30000);

    // Reset with three sets in flight
    step();
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b1); step();
    applyStimulus(16'h3333, 16'h4444, 1'b0, 1'b1); step();
    applyStimulus(16'h5555, 16'h6666, 1'b0, 1'b1); step();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_sum_co",    64'({co, s}),   64'd0);
    checkOutput("midrst_in_ready",  64'(in_ready),  64'd1);
    step();
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      stale = stale | out_valid;
    end
    checkOutput("midrst_no_stale", 64'(stale), 64'd0);

    // Parameter sweep, first vector is 0xFF + 0x01 for the 8/4 boundary case
    sweepVector(32'h000000FE, 32'h00000001, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      sweepVector($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'b0);
    end
    sweepVector(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
